instr_fetch_mem: RTL and testbench

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

---
 rtl/instr_fetch_mem.sv | 99 +++++++++
 tb/tb_instr_fetch_mem.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: registered fetch port with legality checking and stall hold,
// plus a program-load write port and a wrapping fetch counter.
module instr_fetch_mem #(
   parameter int    DATA_W    = 32,
   parameter int    DEPTH     = 128,
   parameter int    ADDR_W    = 32,
   parameter int    CNT_W     = 16,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] address,
   input  logic              stall,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              fetch_err,
   output logic              prog_err,
   output logic [CNT_W-1:0]  fetch_count
);

   localparam int                OFF     = $clog2(DATA_W / 8);
   localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [DATA_W-1:0] data_out_q,    data_out_d;
   logic              data_valid_q,  data_valid_d;
   logic              fetch_err_q,   fetch_err_d;
   logic              prog_err_q,    prog_err_d;
   logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

   logic fetch_ok;
   logic prog_ok;

   function automatic logic is_legal(input logic [ADDR_W-1:0] a);
      return (a[OFF-1:0] == '0) && ((a >> OFF) < DEPTH_A);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'(a >> OFF);
   endfunction

   // Power-on image: all NOPs.
   initial begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
   end

   always_comb begin
      fetch_ok      = is_legal(address);
      prog_ok       = is_legal(prog_addr);
      data_out_d    = data_out_q;
      data_valid_d  = data_valid_q;
      fetch_err_d   = fetch_err_q;
      fetch_count_d = fetch_count_q;
      prog_err_d    = prog_we & ~prog_ok;
      if (!stall) begin
         if (fetch_req) begin
            data_out_d    = fetch_ok ? mem[word_idx(address)] : '0;
            data_valid_d  = 1'b1;
            fetch_err_d   = ~fetch_ok;
            fetch_count_d = fetch_count_q + 1'b1;
         end else begin
            data_valid_d  = 1'b0;
            fetch_err_d   = 1'b0;
         end
      end
   end

   // Memory write shares the reset branch so writes are blocked while reset is high;
   // the array itself is never cleared. Read-before-write falls out of the NBA ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out_q    <= '0;
         data_valid_q  <= 1'b0;
         fetch_err_q   <= 1'b0;
         prog_err_q    <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         data_out_q    <= data_out_d;
         data_valid_q  <= data_valid_d;
         fetch_err_q   <= fetch_err_d;
         prog_err_q    <= prog_err_d;
         fetch_count_q <= fetch_count_d;
         if (prog_we && prog_ok) mem[word_idx(prog_addr)] <= prog_data;
      end
   end

   assign data_out    = data_out_q;
   assign data_valid  = data_valid_q;
   assign fetch_err   = fetch_err_q;
   assign prog_err    = prog_err_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Testbench for instr_fetch_mem: directed scenarios plus randomized traffic checked
// against a word-array reference model of the fetch/program rules.
module tb_instr_fetch_mem;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int CW = 4;
   localparam int NW = 128;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          fetch_req = 1'b0;
   logic [AW-1:0] address = '0;
   logic          stall = 1'b0;
   logic          prog_we = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [DW-1:0] prog_data = '0;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          fetch_err;
   logic          prog_err;
   logic [CW-1:0] fetch_count;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] ref_mem [NW];
   logic [DW-1:0] exp_data = '0;
   logic          exp_valid = 1'b0;
   logic          exp_err = 1'b0;
   logic          exp_perr = 1'b0;
   int            exp_cnt = 0;

   instr_fetch_mem #(
      .DATA_W(DW), .DEPTH(NW), .ADDR_W(AW), .CNT_W(CW), .INIT_FILE("")
   ) dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .address(address),
      .stall(stall), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .data_out(data_out), .data_valid(data_valid), .fetch_err(fetch_err),
      .prog_err(prog_err), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   function automatic bit legal(input logic [AW-1:0] a);
      return (a % 4 == 0) && (a / 4 < NW);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".data_out"}, 64'(data_out), 64'(exp_data));
      chk({tag, ".data_valid"}, 64'(data_valid), 64'(exp_valid));
      chk({tag, ".fetch_err"}, 64'(fetch_err), 64'(exp_err));
      chk({tag, ".prog_err"}, 64'(prog_err), 64'(exp_perr));
      chk({tag, ".fetch_count"}, 64'(fetch_count), 64'(exp_cnt));
   endtask

   task automatic model_reset();
      exp_data = '0; exp_valid = 1'b0; exp_err = 1'b0; exp_perr = 1'b0; exp_cnt = 0;
   endtask

   // Apply one clock of inputs, advance the model on the edge, check 1 time unit later.
   task automatic step(input string tag, input logic fr, input logic [AW-1:0] a,
                       input logic st, input logic we, input logic [AW-1:0] pa,
                       input logic [DW-1:0] pd);
      logic [DW-1:0] old_word;
      fetch_req = fr; address = a; stall = st;
      prog_we = we; prog_addr = pa; prog_data = pd;
      @(posedge clk);
      old_word = legal(a) ? ref_mem[a / 4] : '0;
      if (!st) begin
         if (fr) begin
            exp_data = old_word; exp_valid = 1'b1; exp_err = !legal(a);
            exp_cnt = (exp_cnt + 1) % (1 << CW);
         end else begin
            exp_valid = 1'b0; exp_err = 1'b0;
         end
      end
      exp_perr = we && !legal(pa);
      if (we && legal(pa)) ref_mem[pa / 4] = pd;
      #1;
      check_all(tag);
   endtask

   function automatic logic [AW-1:0] rand_addr(input int lo);
      case ($urandom_range(0, 5))
         0: return AW'($urandom_range(lo, NW - 1) * 4 + $urandom_range(1, 3));
         1: return AW'($urandom_range(NW, 4000) * 4);
         default: return AW'($urandom_range(lo, NW - 1) * 4);
      endcase
   endfunction

   initial begin
      int c0;
      for (int i = 0; i < NW; i++) ref_mem[i] = '0;
      model_reset();
      #1;
      check_all("reset");
      @(negedge clk);
      reset = 1'b0;

      // write then read word 0
      step("wr0", 0, 0, 0, 1, 0, 32'h8E08_0200);
      step("rd0", 1, 0, 0, 0, 0, 0);
      chk("rd0.const_data", 64'(data_out), 64'h8E08_0200);
      chk("rd0.const_cnt", 64'(fetch_count), 64'd1);

      // illegal fetches: misaligned, then out of range
      step("ill6", 1, 6, 0, 0, 0, 0);
      chk("ill6.const_err", 64'(fetch_err), 64'd1);
      step("ill512", 1, 512, 0, 0, 0, 0);
      chk("ill512.const_data", 64'(data_out), 64'd0);
      chk("ill512.const_cnt", 64'(fetch_count), 64'd3);
      step("idle", 0, 0, 0, 0, 0, 0);

      // stall holds the response
      step("wr4", 0, 0, 0, 1, 4, 32'h8E09_0300);
      step("rd4", 1, 4, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step("stall", 1, 8, 1, 0, 0, 0);
         chk("stall.const_data", 64'(data_out), 64'h8E09_0300);
         chk("stall.const_cnt", 64'(fetch_count), 64'd4);
      end

      // same-word write/fetch collision
      step("coll", 1, 176, 0, 1, 176, 32'hAD0E_0100);
      chk("coll.const_old", 64'(data_out), 64'd0);
      step("coll2", 1, 176, 0, 0, 0, 0);
      chk("coll2.const_new", 64'(data_out), 64'hAD0E_0100);

      // rejected program write: one-cycle pulse, memory untouched
      step("perr", 0, 0, 0, 1, 2, 32'hFFFF_FFFF);
      chk("perr.const", 64'(prog_err), 64'd1);
      step("perr_end", 1, 0, 0, 0, 0, 0);
      chk("perr_end.const", 64'(prog_err), 64'd0);
      chk("perr_end.word0", 64'(data_out), 64'h8E08_0200);

      // counter wrap over 17 accepted fetches
      c0 = exp_cnt;
      for (int i = 0; i < 17; i++) step("wrap", 1, AW'(i * 4), 0, 0, 0, 0);
      chk("wrap.const", 64'(fetch_count), 64'((c0 + 1) % 16));

      // randomized traffic; program writes avoid words 0 and 1
      for (int i = 0; i < 300; i++) begin
         step("rand", 1'($urandom_range(0, 3) != 0), rand_addr(0),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
              rand_addr(2), DW'($urandom));
      end

      // async reset mid-cycle during streaming fetches
      step("stream", 1, 0, 0, 0, 0, 0);
      fetch_req = 1'b1; address = 4;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_all("async_rst");
      prog_we = 1'b1; prog_addr = 12; prog_data = 32'h1234_5678;
      @(posedge clk);
      #1;
      check_all("in_rst");
      @(negedge clk);
      reset = 1'b0;
      step("post_rst_idle", 0, 0, 0, 0, 0, 0);
      step("post_rst_rd0", 1, 0, 0, 0, 0, 0);
      chk("post_rst_rd0.const", 64'(data_out), 64'h8E08_0200);
      step("post_rst_rd3", 1, 12, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
